uart_cmd_rx: RTL and testbench

UART_CMD_RX -- requirements
Module: uart_cmd_rx

---
 rtl/awg_uart_pkg.sv | 24 ++
 rtl/uart_rx_sampler.sv | 58 +++++
 rtl/uart_cmd_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/awg_uart_pkg.sv
// Shared definitions for the UART command receiver: FSM states, parity
// encodings and the sample-tick divider calculation.
package awg_uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } rx_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Clocks per sample tick, truncated, never below 1.
   function automatic int calc_div(input int clk_freq, input int baud, input int os);
      int d;
      d = clk_freq / (baud * os);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Sample-tick divider plus 2-of-3 majority voter. Counters are held at zero
// while clear_i is high so every frame starts its bit timing from the start
// edge. vote_vld_o pulses once per bit, on the third mid-bit sample.
module uart_rx_sampler
   import awg_uart_pkg::*;
#(
   parameter int DIV        = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic rxd_i,
   output logic vote_vld_o,
   output logic vote_o
);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] M0 = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] M1 = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] M2 = SW'(OVERSAMPLE / 2 + 1);

   logic [DW-1:0] div_q, div_d;
   logic [SW-1:0] smp_q, smp_d;
   logic [1:0]    s_q, s_d;
   logic          tick;

   // Next-state for divider, in-bit sample index and the two early samples
   always_comb begin
      tick  = (div_q == DW'(DIV - 1));
      div_d = tick ? '0 : div_q + 1'b1;
      smp_d = tick ? smp_q + 1'b1 : smp_q;
      s_d   = s_q;
      if (tick && smp_q == M0) s_d[0] = rxd_i;
      if (tick && smp_q == M1) s_d[1] = rxd_i;
      if (clear_i) begin
         div_d = '0;
         smp_d = '0;
      end
   end

   // Counter and sample registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q <= '0;
         smp_q <= '0;
         s_q   <= 2'b11;
      end else begin
         div_q <= div_d;
         smp_q <= smp_d;
         s_q   <= s_d;
      end
   end

   assign vote_vld_o = tick && !clear_i && (smp_q == M2);
   assign vote_o     = (s_q[0] & s_q[1]) | (s_q[0] & rxd_i) | (s_q[1] & rxd_i);

endmodule

// File: rtl/uart_cmd_rx.sv
// UART receiver with a one-deep hold register and command-field decode.
// Bits are acted on at the mid-bit vote, so the FSM advances mid-bit and a
// frame completes in the middle of its stop bit.
module uart_cmd_rx
   import awg_uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int OVERSAMPLE = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_Pin_In,
   input  logic       RX_En_Sig,
   input  logic       RX_Ready,
   output logic [7:0] RX_Data,
   output logic [3:0] Set,
   output logic [1:0] Type,
   output logic       RX_Valid,
   output logic       RX_Frame_Err,
   output logic       RX_Parity_Err,
   output logic       RX_Overrun
);
   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int CW  = $clog2(DATA_BITS);

   logic [1:0]           sync_q, flush_q;
   logic                 prev_q, rxd, fall;
   rx_state_e            state_q, state_d;
   logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_err_q, par_err_d;
   logic [7:0]           data_q, data_d;
   logic                 valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
   logic                 samp_clr, vote_vld, vote, frame_done, stop_bad, accept;

   // Synchronizer and edge history. prev_q only arms once the reset value has
   // flushed out of the synchronizer, so a line already low at reset release
   // is not mistaken for a start edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q  <= 2'b11;
         flush_q <= 2'b00;
         prev_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], RX_Pin_In};
         flush_q <= {flush_q[0], 1'b1};
         prev_q  <= sync_q[1] & flush_q[1];
      end
   end

   assign rxd      = sync_q[1];
   assign fall     = prev_q & ~rxd;
   assign samp_clr = (state_q == S_IDLE);

   uart_rx_sampler #(
      .DIV        (DIV),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_sampler (
      .clk_i      (CLK),
      .rst_i      (RST),
      .clear_i    (samp_clr),
      .rxd_i      (rxd),
      .vote_vld_o (vote_vld),
      .vote_o     (vote)
   );

   // Frame FSM next-state: start check, LSB-first shift, parity, stop
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_err_d  = par_err_q;
      frame_done = 1'b0;
      stop_bad   = 1'b0;
      case (state_q)
         S_IDLE: begin
            bit_cnt_d = '0;
            par_err_d = 1'b0;
            if (RX_En_Sig && fall) state_d = S_START;
         end
         S_START: if (vote_vld) state_d = vote ? S_IDLE : S_DATA;
         S_DATA: if (vote_vld) begin
            shift_d = {vote, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == CW'(DATA_BITS - 1))
               state_d = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
            else
               bit_cnt_d = bit_cnt_q + 1'b1;
         end
         S_PAR: if (vote_vld) begin
            par_err_d = (PARITY == PAR_ODD) ? ~(^shift_q ^ vote) : (^shift_q ^ vote);
            state_d   = S_STOP;
         end
         S_STOP: if (vote_vld) begin
            state_d    = S_IDLE;
            frame_done = 1'b1;
            stop_bad   = ~vote;
         end
         default: state_d = S_IDLE;
      endcase
      // Losing the enable throws the partial frame away
      if (state_q != S_IDLE && !RX_En_Sig) begin
         state_d    = S_IDLE;
         frame_done = 1'b0;
      end
   end

   // Hold register: load on completion unless a held frame is not being
   // taken this clock, in which case the new frame is dropped as overrun
   always_comb begin
      accept  = valid_q & RX_Ready;
      data_d  = data_q;
      ferr_d  = ferr_q;
      perr_d  = perr_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (accept) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
      if (frame_done) begin
         if (!valid_q || RX_Ready) begin
            data_d  = 8'(shift_q);
            ferr_d  = stop_bad;
            perr_d  = par_err_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   // FSM, datapath and hold registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_err_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         perr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_err_q <= par_err_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         perr_q    <= perr_d;
         ovr_q     <= ovr_d;
      end
   end

   assign RX_Data       = data_q;
   assign Set           = {data_q[2], data_q[3], data_q[4], data_q[5]};
   assign Type          = {data_q[0], data_q[1]};
   assign RX_Valid      = valid_q;
   assign RX_Frame_Err  = ferr_q;
   assign RX_Parity_Err = perr_q;
   assign RX_Overrun    = ovr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench: three receivers at 16 clocks/bit. Lane 0 is 8N1, lane 1 is
// 8E1, lane 2 is 7N1. Clock period 10, so one nominal bit is 160.
module tb_uart_cmd_rx;

   logic       clk, rst, en;
   logic       rx   [3];
   logic       rdy  [3];
   logic [7:0] dat  [3];
   logic [3:0] set  [3];
   logic [1:0] typ  [3];
   logic       vld  [3];
   logic       ferr [3];
   logic       perr [3];
   logic       ovr  [3];

   int         tests = 0;
   int         fails = 0;
   int         base;

   // valid-cycle counters and data captured while RX_Valid is high
   int         vcyc  [3] = '{default: 0};
   logic [7:0] cdat  [3];
   logic       cferr [3];
   logic       cperr [3];
   logic [3:0] cset;
   logic [1:0] ctyp;

   uart_cmd_rx #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(0), .OVERSAMPLE(16)) u_a (
      .CLK(clk), .RST(rst), .RX_Pin_In(rx[0]), .RX_En_Sig(en), .RX_Ready(rdy[0]),
      .RX_Data(dat[0]), .Set(set[0]), .Type(typ[0]), .RX_Valid(vld[0]),
      .RX_Frame_Err(ferr[0]), .RX_Parity_Err(perr[0]), .RX_Overrun(ovr[0]));

   uart_cmd_rx #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(2), .OVERSAMPLE(16)) u_b (
      .CLK(clk), .RST(rst), .RX_Pin_In(rx[1]), .RX_En_Sig(en), .RX_Ready(rdy[1]),
      .RX_Data(dat[1]), .Set(set[1]), .Type(typ[1]), .RX_Valid(vld[1]),
      .RX_Frame_Err(ferr[1]), .RX_Parity_Err(perr[1]), .RX_Overrun(ovr[1]));

   uart_cmd_rx #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .DATA_BITS(7), .PARITY(0), .OVERSAMPLE(16)) u_c (
      .CLK(clk), .RST(rst), .RX_Pin_In(rx[2]), .RX_En_Sig(en), .RX_Ready(rdy[2]),
      .RX_Data(dat[2]), .Set(set[2]), .Type(typ[2]), .RX_Valid(vld[2]),
      .RX_Frame_Err(ferr[2]), .RX_Parity_Err(perr[2]), .RX_Overrun(ovr[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // capture whatever is presented while RX_Valid is high
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (vld[i]) begin
            vcyc[i]  <= vcyc[i] + 1;
            cdat[i]  <= dat[i];
            cferr[i] <= ferr[i];
            cperr[i] <= perr[i];
         end
      end
      if (vld[0]) begin
         cset <= set[0];
         ctyp <= typ[0];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // pbit < 0 means no parity bit; bt is the bit period in time units
   task automatic send(input int ln, input logic [7:0] d, input int nb, input int pbit,
                       input logic stop, input int bt);
      rx[ln] = 1'b0;
      #(bt);
      for (int i = 0; i < nb; i++) begin
         rx[ln] = d[i];
         #(bt);
      end
      if (pbit >= 0) begin
         rx[ln] = pbit[0];
         #(bt);
      end
      rx[ln] = stop;
      #(bt);
      rx[ln] = 1'b1;
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rx[i]  = 1'b1;
         rdy[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      check("rst_data",  32'(dat[0]), 32'h00);
      check("rst_set",   32'(set[0]), 32'h0);
      check("rst_type",  32'(typ[0]), 32'h0);
      check("rst_valid", 32'(vld[0]), 32'h0);
      check("rst_ferr",  32'(ferr[0]), 32'h0);
      check("rst_perr",  32'(perr[0]), 32'h0);
      check("rst_ovr",   32'(ovr[0]), 32'h0);
      check("rst_valid_b", 32'(vld[1]), 32'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // clean 8N1 frame, consumer always ready
      base = vcyc[0];
      send(0, 8'h2D, 8, -1, 1'b1, 160);
      settle();
      check("clean_vcyc",  32'(vcyc[0] - base), 32'd1);
      check("clean_data",  32'(cdat[0]), 32'h2D);
      check("clean_set",   32'(cset), 32'b1101);
      check("clean_type",  32'(ctyp), 32'b10);   // {D0,D1} of 0x2D
      check("clean_ferr",  32'(cferr[0]), 32'h0);
      check("clean_perr",  32'(cperr[0]), 32'h0);
      check("clean_ovr",   32'(ovr[0]), 32'h0);
      check("clean_vld_low", 32'(vld[0]), 32'h0);

      // short low glitch on idle line
      base = vcyc[0];
      rx[0] = 1'b0;
      #40;
      rx[0] = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch_vcyc", 32'(vcyc[0] - base), 32'd0);

      // framing error, held with consumer not ready
      rdy[0] = 1'b0;
      send(0, 8'h55, 8, -1, 1'b0, 160);
      settle();
      check("ferr_valid", 32'(vld[0]), 32'h1);
      check("ferr_data",  32'(dat[0]), 32'h55);
      check("ferr_flag",  32'(ferr[0]), 32'h1);
      check("ferr_ovr",   32'(ovr[0]), 32'h0);
      rdy[0] = 1'b1;
      repeat (2) @(negedge clk);
      check("ferr_taken", 32'(vld[0]), 32'h0);

      // overrun: two back-to-back frames with no acceptance
      rdy[0] = 1'b0;
      send(0, 8'h11, 8, -1, 1'b1, 160);
      send(0, 8'h22, 8, -1, 1'b1, 160);
      settle();
      check("ovr_data",  32'(dat[0]), 32'h11);
      check("ovr_flag",  32'(ovr[0]), 32'h1);
      check("ovr_valid", 32'(vld[0]), 32'h1);
      check("ovr_ferr",  32'(ferr[0]), 32'h0);
      rdy[0] = 1'b1;
      @(posedge clk);
      #1;
      check("ovr_clr_valid", 32'(vld[0]), 32'h0);
      check("ovr_clr_flag",  32'(ovr[0]), 32'h0);
      @(negedge clk);

      // enable dropped during data bit 3
      base = vcyc[0];
      fork
         send(0, 8'h5A, 8, -1, 1'b1, 160);
         begin
            #(4 * 160 + 80);
            en = 1'b0;
         end
      join
      repeat (5) @(negedge clk);
      en = 1'b1;
      check("abort_vcyc", 32'(vcyc[0] - base), 32'd0);
      repeat (2) @(negedge clk);
      base = vcyc[0];
      send(0, 8'hA7, 8, -1, 1'b1, 160);
      settle();
      check("post_abort_vcyc", 32'(vcyc[0] - base), 32'd1);
      check("post_abort_data", 32'(cdat[0]), 32'hA7);
      check("post_abort_ferr", 32'(cferr[0]), 32'h0);

      // reset pulse during data bit 5; line stays low afterwards until stop
      base = vcyc[0];
      fork
         send(0, 8'h1F, 8, -1, 1'b1, 160);
         begin
            #(6 * 160 + 20);
            rst = 1'b1;
            #20;
            rst = 1'b0;
         end
      join
      repeat (5) @(negedge clk);
      check("rst_mid_vcyc", 32'(vcyc[0] - base), 32'd0);
      check("rst_mid_data", 32'(dat[0]), 32'h00);
      base = vcyc[0];
      send(0, 8'hA7, 8, -1, 1'b1, 160);
      settle();
      check("post_rst_vcyc", 32'(vcyc[0] - base), 32'd1);
      check("post_rst_data", 32'(cdat[0]), 32'hA7);

      // even parity lane: 0x03 has even weight, so parity bit 1 is wrong
      base = vcyc[1];
      send(1, 8'h03, 8, 1, 1'b1, 160);
      settle();
      check("par_bad_vcyc", 32'(vcyc[1] - base), 32'd1);
      check("par_bad_data", 32'(cdat[1]), 32'h03);
      check("par_bad_flag", 32'(cperr[1]), 32'h1);
      check("par_bad_ferr", 32'(cferr[1]), 32'h0);
      send(1, 8'h03, 8, 0, 1'b1, 160);
      settle();
      check("par_ok_data", 32'(cdat[1]), 32'h03);
      check("par_ok_flag", 32'(cperr[1]), 32'h0);

      // 7-bit lane at about +3% and -3% bit period
      base = vcyc[2];
      send(2, 8'hC3, 7, -1, 1'b1, 155);
      settle();
      check("fast_vcyc", 32'(vcyc[2] - base), 32'd1);
      check("fast_data", 32'(cdat[2]), 32'h43);
      check("fast_ferr", 32'(cferr[2]), 32'h0);
      base = vcyc[2];
      send(2, 8'hC3, 7, -1, 1'b1, 165);
      settle();
      check("slow_vcyc", 32'(vcyc[2] - base), 32'd1);
      check("slow_data", 32'(cdat[2]), 32'h43);
      check("slow_ferr", 32'(cferr[2]), 32'h0);
      check("slow_ovr",  32'(ovr[2]), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
